// File: rtl/pwm_pkg.sv
// Shared types and helpers for the centre-aligned PWM arm scheduler.
// Functions work on plain ints so any counter width can reuse them.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Saturate a requested duty to the half-carrier length (100% on-time).
    function automatic int clamp_duty(input int duty, input int limit);
        return (duty > limit) ? limit : duty;
    endfunction

    // Low bit index of arm k (1-based) inside the packed Duty word.
    function automatic int arm_field(input int k, input int width);
        return (k - 1) * width;
    endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Triangular up/down carrier: 0..Period-1 up, then Period-1..0 down.
// Flags mark the first (start) and last (end) clock of each PWM period.
module pwm_carrier #(
    parameter int  Period = 500,
    localparam int CntW   = $clog2(Period + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            run,
    output logic [CntW-1:0] count,
    output logic            period_start,
    output logic            period_end
);

    localparam logic [CntW-1:0] CountMax = CntW'(Period - 1);

    logic dir_down;

    // The turning points repeat their value once, so every count occurs twice per period.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count    <= '0;
            dir_down <= 1'b0;
        end else if (run) begin
            if (!dir_down) begin
                if (count == CountMax) begin
                    dir_down <= 1'b1;
                end else begin
                    count <= count + CntW'(1);
                end
            end else begin
                if (count == '0) begin
                    dir_down <= 1'b0;
                end else begin
                    count <= count - CntW'(1);
                end
            end
        end
    end

    assign period_start = (count == '0) && !dir_down;
    assign period_end   = (count == '0) && dir_down;

endmodule

// File: rtl/pwm_arm_scheduler.sv
// Centre-aligned PWM scheduler: carrier, double-buffered duty with valid/ready
// load, run/fault sequencing and registered complementary switch commands.
module pwm_arm_scheduler
    import pwm_pkg::*;
#(
    parameter int  ArmNum = 2,
    parameter int  Period = 500,
    localparam int SWNum  = 2 * ArmNum,
    localparam int CntW   = $clog2(Period + 1)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   Fault,
    input  logic [ArmNum*CntW-1:0] Duty,
    input  logic                   DutyValid,
    output logic                   DutyReady,
    output logic [SWNum:1]         SW,
    output logic                   Sync,
    output logic                   Running,
    output logic                   Tripped
);

    state_t state;
    state_t state_next;

    logic [CntW-1:0] count;
    logic            period_start;
    logic            period_end;
    logic            in_run;
    logic            in_idle;
    logic            carrier_clear;

    logic [CntW-1:0] duty_word   [ArmNum];
    logic [CntW-1:0] shadow_duty [ArmNum];
    logic [CntW-1:0] active_duty [ArmNum];
    logic            shadow_full;
    logic            accept;
    logic            load_active;

    logic [SWNum:1]  sw_next;
    logic            sync_next;

    assign in_run  = (state == RUN);
    assign in_idle = (state == IDLE);

    // Clearing on the transition edge keeps the carrier at 0/up for the whole
    // IDLE/FAULT stay and hands RUN a fresh period start.
    assign carrier_clear = (state_next != RUN);

    pwm_carrier #(
        .Period(Period)
    ) u_carrier (
        .clk          (Clock),
        .rst          (Reset),
        .clear        (carrier_clear),
        .run          (in_run),
        .count        (count),
        .period_start (period_start),
        .period_end   (period_end)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Fault) begin
                    state_next = FAULT;
                end else if (Enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (Fault) begin
                    state_next = FAULT;
                end else if (!Enable && period_end) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                // Enable must be dropped before the trip clears: explicit re-arm.
                if (!Fault && !Enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake: a word transfers on any edge where DutyValid and DutyReady are both high.
    assign DutyReady   = ~shadow_full;
    assign accept      = DutyValid & ~shadow_full;
    assign load_active = shadow_full & (in_idle | (in_run & period_end));

    always_comb begin
        for (int k = 0; k < ArmNum; k++) begin
            duty_word[k] = CntW'(clamp_duty(int'(Duty[arm_field(k + 1, CntW) +: CntW]), Period));
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            shadow_full <= 1'b0;
            for (int k = 0; k < ArmNum; k++) begin
                shadow_duty[k] <= '0;
                active_duty[k] <= '0;
            end
        end else begin
            if (accept) begin
                shadow_full <= 1'b1;
            end else if (load_active) begin
                shadow_full <= 1'b0;
            end
            for (int k = 0; k < ArmNum; k++) begin
                if (accept) begin
                    shadow_duty[k] <= duty_word[k];
                end
                if (load_active) begin
                    active_duty[k] <= shadow_duty[k];
                end
            end
        end
    end

    // Fault gates the outputs combinationally so the switches drop on the very next edge.
    always_comb begin
        sw_next   = '0;
        sync_next = 1'b0;
        if (in_run && !Fault) begin
            sync_next = period_start;
            for (int k = 0; k < ArmNum; k++) begin
                sw_next[2*k+1] = (count < active_duty[k]);
                sw_next[2*k+2] = ~sw_next[2*k+1];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            SW   <= '0;
            Sync <= 1'b0;
        end else begin
            SW   <= sw_next;
            Sync <= sync_next;
        end
    end

    assign Running = in_run;
    assign Tripped = (state == FAULT);

endmodule

// File: tb/tb_pwm_arm_scheduler.sv
// Directed bench for pwm_arm_scheduler with Period=10, ArmNum=2 (4-bit duty fields).
// A duty table drives full-period on-time checks; hand sequences cover the corners.
module tb_pwm_arm_scheduler;

    localparam int ArmNum = 2;
    localparam int Period = 10;
    localparam int CntW   = 4;
    localparam int SWNum  = 4;

    logic                   Clock = 1'b0;
    logic                   Reset;
    logic                   Enable;
    logic                   Fault;
    logic [ArmNum*CntW-1:0] Duty;
    logic                   DutyValid;
    logic                   DutyReady;
    logic [SWNum:1]         SW;
    logic                   Sync;
    logic                   Running;
    logic                   Tripped;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] duty;
        int         exp_hi1;
        int         exp_hi3;
    } vec_t;

    vec_t vecs [5];

    pwm_arm_scheduler #(
        .ArmNum(ArmNum),
        .Period(Period)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Fault     (Fault),
        .Duty      (Duty),
        .DutyValid (DutyValid),
        .DutyReady (DutyReady),
        .SW        (SW),
        .Sync      (Sync),
        .Running   (Running),
        .Tripped   (Tripped)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic wait_sync(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (Sync !== 1'b1 && n < 60);
        check("sync_seen", Sync, 1);
    endtask

    // Caller is positioned on a Sync sample; walks the 20 samples of that period.
    task automatic measure_period(input string tag, input int e1, input int e3);
        int hi1;
        int hi3;
        int bad;
        int stray;
        hi1   = 0;
        hi3   = 0;
        bad   = 0;
        stray = 0;
        for (int j = 0; j < 2 * Period; j++) begin
            if (j > 0) tick();
            if (SW[1] === 1'b1) hi1++;
            if (SW[3] === 1'b1) hi3++;
            if (SW[2] !== ~SW[1] || SW[4] !== ~SW[3]) bad++;
            if (j > 0 && Sync !== 1'b0) stray++;
        end
        check($sformatf("%s_hi1", tag), hi1, e1);
        check($sformatf("%s_hi3", tag), hi3, e3);
        check($sformatf("%s_complement", tag), bad, 0);
        check($sformatf("%s_stray_sync", tag), stray, 0);
    endtask

    initial begin
        int n;
        int stall;
        int hi1;
        logic run18;

        // {arm2, arm1}; on-time = 2 * min(duty, 10)
        vecs[0] = '{duty: 8'hF0, exp_hi1: 0,  exp_hi3: 20};
        vecs[1] = '{duty: 8'h0A, exp_hi1: 20, exp_hi3: 0};
        vecs[2] = '{duty: 8'h1F, exp_hi1: 20, exp_hi3: 2};
        vecs[3] = '{duty: 8'h95, exp_hi1: 10, exp_hi3: 18};
        vecs[4] = '{duty: 8'h4B, exp_hi1: 20, exp_hi3: 8};

        Reset     = 1'b1;
        Enable    = 1'b0;
        Fault     = 1'b0;
        DutyValid = 1'b0;
        Duty      = '0;
        tick();
        tick();
        check("rst_sw", SW, 0);
        check("rst_sync", Sync, 0);
        check("rst_running", Running, 0);
        check("rst_tripped", Tripped, 0);
        check("rst_ready", DutyReady, 1);
        Reset = 1'b0;
        tick();
        check("idle_sw", SW, 0);
        check("idle_running", Running, 0);

        // Word offered together with Enable: first period still uses 0/0.
        Duty      = 8'h37;
        DutyValid = 1'b1;
        Enable    = 1'b1;
        tick();
        DutyValid = 1'b0;
        check("start_running", Running, 1);
        check("start_ready", DutyReady, 0);
        check("start_sw", SW, 0);
        wait_sync(n);
        check("first_sync_latency", n, 1);
        check("first_sw", SW, 4'b1010);
        measure_period("p1", 0, 0);
        check("p1_end_ready", DutyReady, 1);
        wait_sync(n);
        check("p2_sync_spacing", n, 1);
        measure_period("p2", 14, 6);

        for (int i = 0; i < 5; i++) begin
            wait_sync(n);
            check($sformatf("vec%0d_spacing", i), n, 1);
            check($sformatf("vec%0d_ready", i), DutyReady, 1);
            Duty      = vecs[i].duty;
            DutyValid = 1'b1;
            tick();
            DutyValid = 1'b0;
            check($sformatf("vec%0d_full", i), DutyReady, 0);
            wait_sync(n);
            check($sformatf("vec%0d_to_sync", i), n, 19);
            measure_period($sformatf("vec%0d", i), vecs[i].exp_hi1, vecs[i].exp_hi3);
        end

        // Back-to-back words: second stalls until the period end.
        wait_sync(n);
        Duty      = 8'h28;
        DutyValid = 1'b1;
        tick();
        check("b2b_first_taken", DutyReady, 0);
        Duty  = 8'h91;
        stall = 0;
        while (DutyReady !== 1'b1 && stall < 40) begin
            tick();
            stall++;
        end
        check("b2b_stall", stall, 18);
        tick();
        DutyValid = 1'b0;
        check("b2b_second_sync", Sync, 1);
        check("b2b_second_taken", DutyReady, 0);
        measure_period("b2b_w1", 16, 4);
        wait_sync(n);
        check("b2b_spacing", n, 1);
        measure_period("b2b_w2", 2, 18);

        // Fault mid-period, latch with Enable high, handshake during FAULT.
        wait_sync(n);
        repeat (5) tick();
        Fault = 1'b1;
        tick();
        check("fault_sw", SW, 0);
        check("fault_tripped", Tripped, 1);
        check("fault_running", Running, 0);
        check("fault_sync", Sync, 0);
        Fault = 1'b0;
        tick();
        tick();
        check("fault_latched", Tripped, 1);
        check("fault_latched_sw", SW, 0);
        check("fault_ready", DutyReady, 1);
        Duty      = 8'h46;
        DutyValid = 1'b1;
        tick();
        DutyValid = 1'b0;
        check("fault_shadow_full", DutyReady, 0);
        Enable = 1'b0;
        tick();
        check("rearm_tripped", Tripped, 0);
        check("rearm_running", Running, 0);
        Enable = 1'b1;
        tick();
        check("restart_running", Running, 1);
        check("restart_loaded", DutyReady, 1);
        wait_sync(n);
        check("restart_sync_latency", n, 1);
        measure_period("restart", 12, 8);

        // Enable dropped at counter 5 (up): period completes, then off.
        wait_sync(n);
        hi1   = (SW[1] === 1'b1) ? 1 : 0;
        run18 = 1'b0;
        for (int j = 1; j < 2 * Period; j++) begin
            if (j == 5) Enable = 1'b0;
            tick();
            if (SW[1] === 1'b1) hi1++;
            if (j == 18) run18 = Running;
        end
        check("drop_hi1", hi1, 12);
        check("drop_running_before_end", run18, 1);
        check("drop_running_at_end", Running, 0);
        check("drop_last_sw", SW, 4'b0101);
        tick();
        check("drop_sw_off", SW, 0);
        check("drop_sync_off", Sync, 0);

        // Fault and Enable=0 together on the period-end cycle: FAULT wins.
        Enable = 1'b1;
        tick();
        wait_sync(n);
        check("pe_sync_latency", n, 1);
        repeat (18) tick();
        Fault  = 1'b1;
        Enable = 1'b0;
        tick();
        check("pe_fault_tripped", Tripped, 1);
        check("pe_fault_running", Running, 0);
        check("pe_fault_sw", SW, 0);
        Fault = 1'b0;
        tick();
        check("pe_fault_clear", Tripped, 0);

        // Reset during RUN with the shadow full.
        Enable = 1'b1;
        tick();
        wait_sync(n);
        repeat (3) tick();
        Duty      = 8'h55;
        DutyValid = 1'b1;
        tick();
        DutyValid = 1'b0;
        check("mid_rst_shadow_full", DutyReady, 0);
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        check("mid_rst_sw", SW, 0);
        check("mid_rst_ready", DutyReady, 1);
        check("mid_rst_running", Running, 0);
        check("mid_rst_sync", Sync, 0);
        check("mid_rst_tripped", Tripped, 0);
        Reset = 1'b0;
        tick();
        wait_sync(n);
        check("post_rst_sync_latency", n, 1);
        measure_period("post_rst1", 0, 0);
        wait_sync(n);
        measure_period("post_rst2", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
